// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: TX FIFO, runtime baud divisor, 1/2 stop bits.
// Define UART_TX_PARITY_EN to compile in the optional even/odd parity bit.
module uart_tx_buffered #(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          stop2,
  input  logic [1:0]                    parity_mode,
  input  logic                          wr_en,
  input  logic [PAYLOAD_BITS-1:0]       wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          uart_txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(PAYLOAD_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wptr;
  logic [AW-1:0]           rptr;
  logic                    push;
  logic                    pop;
  logic                    empty;
  logic [PAYLOAD_BITS-1:0] head;

  assign wr_ready = fifo_level != LW'(FIFO_DEPTH);
  assign empty    = fifo_level == '0;
  assign push     = wr_en && wr_ready;
  assign head     = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  state_t                  state;
  logic [DIV_WIDTH-1:0]    cnt;
  logic [DIV_WIDTH-1:0]    div_l;
  logic [BW-1:0]           bit_idx;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic                    stop2_l;
  logic                    stop_idx;
  logic                    bit_end;
  logic                    last_stop;
  logic                    frame_end;
  logic                    load;

`ifdef UART_TX_PARITY_EN
  logic par_en;
  logic par_bit;
`else
  logic unused_cfg;
  assign unused_cfg = ^parity_mode;
`endif

  assign bit_end   = cnt == '0;
  assign last_stop = !stop2_l || stop_idx;
  assign frame_end = (state == STOP) && bit_end && last_stop;
  assign load      = !empty && ((state == IDLE) || frame_end);
  assign pop       = load;

  // Line outputs lag the state by one cycle, so the pad is always a flop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      div_l    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      stop2_l  <= 1'b0;
      stop_idx <= 1'b0;
      uart_txd <= 1'b1;
      tx_done  <= 1'b0;
      tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
`endif
    end else begin
      tx_done <= frame_end;
      tx_busy <= (state != IDLE) || !empty;

      unique case (state)
        IDLE:    uart_txd <= 1'b1;
        START:   uart_txd <= 1'b0;
        DATA:    uart_txd <= shreg[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  uart_txd <= par_bit;
`endif
        STOP:    uart_txd <= 1'b1;
        default: uart_txd <= 1'b1;
      endcase

      if (load) begin
        state    <= START;
        cnt      <= baud_div;
        div_l    <= baud_div;
        stop2_l  <= stop2;
        stop_idx <= 1'b0;
        bit_idx  <= '0;
        shreg    <= head;
`ifdef UART_TX_PARITY_EN
        par_en   <= parity_mode[0] ^ parity_mode[1];
        par_bit  <= (^head) ^ parity_mode[1];
`endif
      end else begin
        if (state != IDLE) cnt <= bit_end ? div_l : cnt - 1'b1;
        if (bit_end) begin
          unique case (state)
            IDLE:  ;
            START: state <= DATA;
            DATA: begin
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == BW'(PAYLOAD_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                state <= par_en ? PARITY : STOP;
`else
                state <= STOP;
`endif
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: state <= STOP;
`endif
            STOP: begin
              if (last_stop) state <= IDLE;
              else stop_idx <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised, buffered UART transmitter for the peripheral bus. A synchronous FIFO decouples the CPU-side writer from the serial line. A runtime-programmable divisor sets the baud rate, with no compile-time clock/baud constants. Frame format is selectable per frame: 1 or 2 stop bits, and optional even/odd parity. The block sits between the memory-mapped UART register file and the `uart_txd` pad.

## Interface
Parameters:
- `PAYLOAD_BITS`, 8, data bits per frame, legal 5..9.
- `FIFO_DEPTH`, 16, TX FIFO entries, power of two, ≥2.
- `DIV_WIDTH`, 16, width of the baud divisor.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: synchronous, active-low reset, sampled on rising `clk`.
- `baud_div` in `DIV_WIDTH`: cycles per bit minus 1; 0 means 1 cycle/bit.
- `stop2` in 1: 1 selects two stop bits, 0 selects one.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 none. Used only when `UART_TX_PARITY_EN` is defined.
- `wr_en` in 1: push `wr_data` into the FIFO.
- `wr_data` in `PAYLOAD_BITS`: byte to send.
- `wr_ready` out 1: FIFO not full.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `tx_busy` out 1: a frame is on the line or the FIFO is non-empty.
- `tx_done` out 1: one-cycle pulse at the end of each frame's last stop bit.
- `uart_txd` out 1: registered serial output; idles high.

## Operation
- Reset values:
  - `uart_txd`=1, `tx_busy`=0, `tx_done`=0, `wr_ready`=1, `fifo_level`=0.
  - FIFO pointers cleared; FSM in IDLE.
- FIFO push:
  - A push occurs when `wr_en && wr_ready`.
  - `wr_en` while full is dropped silently; level and contents are unchanged.
- FIFO pop/push interaction:
  - The FSM pops when it loads a frame.
  - Simultaneous push and pop leaves `fifo_level` unchanged.
  - `wr_ready` = (`fifo_level` != `FIFO_DEPTH`), derived from the registered level. A push in the same cycle as a pop from a full FIFO is therefore dropped.
- Pointer arithmetic: wrap modulo `FIFO_DEPTH`; level is tracked in a separate counter.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty, pop the head into the shift register; go to START.
  - START → DATA after one bit period.
  - DATA: shifts out LSB first, `PAYLOAD_BITS` bits. Then → PARITY if parity is enabled, else → STOP.
  - PARITY → STOP after one bit period.
  - STOP: lasts 1 or 2 bit periods. Then → START (loading the next entry) if FIFO non-empty, else → IDLE.
- Config latch: `baud_div`, `stop2` and `parity_mode` are latched when a frame is loaded. Changes mid-frame take effect on the next frame only.
- Parity bit:
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
- Bit timer: a `DIV_WIDTH` down-counter reloaded with the latched divisor at each bit boundary. Each bit lasts exactly `baud_div`+1 cycles.
- Reset mid-frame:
  - Frame aborted and FIFO flushed.
  - `uart_txd` is 1 from the next edge; no partial stop bit is emitted.

## Timing
- Write-to-start latency: `wr_en` accepted at edge N into an empty idle block → `uart_txd` low from edge N+2.
- Frame length: (1 + `PAYLOAD_BITS` + P + S)·(`baud_div`+1) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- Back-to-back frames: the next start bit immediately follows the last stop bit, with zero idle cycles.
- `tx_done` is high for the final cycle of the last stop bit.
- `tx_busy` falls in the cycle after that, if the FIFO is empty.
- `fifo_level` updates the cycle after a push or pop.
- `uart_txd` is driven from a flop only; no combinational path from inputs to the pad.

## Configuration
- Macro `UART_TX_PARITY_EN`.
  - Defined: PARITY state and `parity_mode` decoding are compiled in.
  - Undefined: `parity_mode` is ignored, the PARITY state is absent, and frames never carry a parity bit.

## Test plan
- Basic frame: `baud_div`=3, `stop2`=0, no parity; write 0xA5 → `uart_txd` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. Total 40 cycles; one `tx_done` pulse.
- Parity (macro defined): `parity_mode`=01, write 0xA5 → parity bit 0. With `parity_mode`=10 → parity bit 1. Frame 44 cycles at `baud_div`=3.
- Stop bits: `stop2`=1, write 0x00 → 9 low bits then 2 high bits. Frame 44 cycles at `baud_div`=3. Toggling `stop2` mid-frame does not alter the current frame.
- FIFO full: hold the line busy and write 17 bytes 0x01..0x11 → `fifo_level`=16, `wr_ready`=0, 0x11 dropped. Only 0x01..0x10 are transmitted, in order.
- Back-to-back: write 0x00 then 0xFF → the second start bit begins the cycle after the first stop bit ends. `tx_busy` stays high throughout.
- Reset mid-frame: assert `resetn`=0 during the DATA state of 0x55 with 3 queued bytes → next edge `uart_txd`=1 and `fifo_level`=0. After release, nothing is transmitted.
